// File: rtl/control_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// control_sequencer_pkg
// Shared RV32I definitions for the control sequencer and the immediate
// extractor: opcode constants, immediate-type codes, writeback and PC source
// encodings, sequencer state encoding and the decoded instruction class.
// ---------------------------------------------------------------------------
package control_sequencer_pkg;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Immediate type presented to the immediate extractor
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_U    = 3'd2,
        IMM_S    = 3'd3,
        IMM_B    = 3'd4,
        IMM_UJ   = 3'd5
    } imm_sel_e;

    // Register-file writeback source
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    // Next-PC source
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_JALR   = 2'd2
    } pc_src_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } state_e;

    // Decoded instruction class; OP and OP-IMM share CLS_ALU
    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_LUI     = 4'd1,
        CLS_AUIPC   = 4'd2,
        CLS_JAL     = 4'd3,
        CLS_JALR    = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_FENCE   = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd10
    } instr_class_e;

    // Classes that produce a register-file result (rd==x0 is filtered separately)
    function automatic logic writes_rd(input instr_class_e cls);
        case (cls)
            CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD: writes_rd = 1'b1;
            default:                                                   writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// ---------------------------------------------------------------------------
// control_sequencer_opcode_decoder
// Purely combinational classification of the latched instruction.
// Ports:
//   opcode    in  7  IR[6:0]
//   funct3    in  3  IR[14:12]
//   funct7_b5 in  1  IR[30] (SUB/SRA select)
//   cls       out    instruction class
//   imm_sel   out    immediate type
//   alu_op    out 4  {funct7[5], funct3} or ADD
//   alu_src_a out 1  0 rs1, 1 PC
//   alu_src_b out 1  0 rs2, 1 immediate
//   wb_sel    out    writeback source
//   illegal   out 1  opcode not part of RV32I
// ---------------------------------------------------------------------------
module control_sequencer_opcode_decoder
    import control_sequencer_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    input  logic         funct7_b5,
    output instr_class_e cls,
    output imm_sel_e     imm_sel,
    output logic [3:0]   alu_op,
    output logic         alu_src_a,
    output logic         alu_src_b,
    output wb_sel_e      wb_sel,
    output logic         illegal
);

    // Opcode classification and datapath control selection
    always_comb begin
        cls       = CLS_ILLEGAL;
        imm_sel   = IMM_NONE;
        alu_op    = 4'b0000;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        wb_sel    = WB_ALU;
        case (opcode)
            OPC_OP: begin
                cls    = CLS_ALU;
                alu_op = {funct7_b5, funct3};
            end
            OPC_OP_IMM: begin
                // IR[30] is immediate data except for the SRLI/SRAI pair
                cls       = CLS_ALU;
                imm_sel   = IMM_I;
                alu_src_b = 1'b1;
                alu_op    = {(funct3 == 3'b101) & funct7_b5, funct3};
            end
            OPC_LUI: begin
                cls       = CLS_LUI;
                imm_sel   = IMM_U;
                alu_src_b = 1'b1;
                wb_sel    = WB_IMM;
            end
            OPC_AUIPC: begin
                cls       = CLS_AUIPC;
                imm_sel   = IMM_U;
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
            end
            OPC_JAL: begin
                cls     = CLS_JAL;
                imm_sel = IMM_UJ;
                wb_sel  = WB_PC4;
            end
            OPC_JALR: begin
                cls       = CLS_JALR;
                imm_sel   = IMM_I;
                alu_src_b = 1'b1;
                wb_sel    = WB_PC4;
            end
            OPC_BRANCH: begin
                cls     = CLS_BRANCH;
                imm_sel = IMM_B;
            end
            OPC_LOAD: begin
                cls       = CLS_LOAD;
                imm_sel   = IMM_I;
                alu_src_b = 1'b1;
                wb_sel    = WB_LOAD;
            end
            OPC_STORE: begin
                cls       = CLS_STORE;
                imm_sel   = IMM_S;
                alu_src_b = 1'b1;
            end
            OPC_FENCE:  cls = CLS_FENCE;
            OPC_SYSTEM: cls = CLS_SYSTEM;
            default:    cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] ->
// WRITEBACK, one instruction in flight. All outputs are registered.
// Ports:
//   CLK, RESET_N              clock, async active-low reset
//   IMEM_REQ/IMEM_READY       instruction fetch handshake, INSTRUCTION data
//   IR                        latched instruction
//   IMM_SELECTION, ALU_OP, ALU_SRC_A, ALU_SRC_B, WB_SEL, PC_SRC
//                             datapath selects, stable DECODE exit..WRITEBACK
//   BRANCH_TAKEN              comparator result, sampled in EXECUTE
//   DMEM_REQ/DMEM_WE/DMEM_READY data access handshake
//   REG_WRITE_EN, PC_WRITE_EN one-cycle WRITEBACK pulses
//   HALT                      sticky stop on ECALL/EBREAK/illegal opcode
// Build option: define INSTRET_COUNTER_EN to add the 64-bit INSTRET output,
// counting WRITEBACK cycles (FENCE included), frozen once halted.
// ---------------------------------------------------------------------------
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    input  logic        IMEM_READY,
    input  logic [31:0] INSTRUCTION,
    output logic [31:0] IR,
    output logic [2:0]  IMM_SELECTION,
    output logic [3:0]  ALU_OP,
    output logic        ALU_SRC_A,
    output logic        ALU_SRC_B,
    input  logic        BRANCH_TAKEN,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    input  logic        DMEM_READY,
    output logic        REG_WRITE_EN,
    output logic [1:0]  WB_SEL,
    output logic        PC_WRITE_EN,
    output logic [1:0]  PC_SRC,
    output logic        HALT
`ifdef INSTRET_COUNTER_EN
    ,
    output logic [63:0] INSTRET
`endif
);

    state_e       state_r;
    instr_class_e cls_r;
    logic [31:0]  ir_r;
    logic         imem_req_r;
    logic         dmem_req_r;
    logic         dmem_we_r;
    logic         reg_write_en_r;
    logic         pc_write_en_r;
    logic         halt_r;
    logic [2:0]   imm_sel_r;
    logic [3:0]   alu_op_r;
    logic         alu_src_a_r;
    logic         alu_src_b_r;
    logic [1:0]   wb_sel_r;
    logic [1:0]   pc_src_r;

    instr_class_e dec_cls_s;
    imm_sel_e     dec_imm_sel_s;
    logic [3:0]   dec_alu_op_s;
    logic         dec_alu_src_a_s;
    logic         dec_alu_src_b_s;
    wb_sel_e      dec_wb_sel_s;
    logic         dec_illegal_s;
    logic         rd_write_s;

    control_sequencer_opcode_decoder u_decoder (
        .opcode    (ir_r[6:0]),
        .funct3    (ir_r[14:12]),
        .funct7_b5 (ir_r[30]),
        .cls       (dec_cls_s),
        .imm_sel   (dec_imm_sel_s),
        .alu_op    (dec_alu_op_s),
        .alu_src_a (dec_alu_src_a_s),
        .alu_src_b (dec_alu_src_b_s),
        .wb_sel    (dec_wb_sel_s),
        .illegal   (dec_illegal_s)
    );

    // Writes to x0 are suppressed here rather than in the register file
    assign rd_write_s = writes_rd(cls_r) && (ir_r[11:7] != 5'd0);

    // Sequencer state, instruction register and all registered control outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r        <= ST_FETCH;
            cls_r          <= CLS_ALU;
            ir_r           <= 32'd0;
            imem_req_r     <= 1'b0;
            dmem_req_r     <= 1'b0;
            dmem_we_r      <= 1'b0;
            reg_write_en_r <= 1'b0;
            pc_write_en_r  <= 1'b0;
            halt_r         <= 1'b0;
            imm_sel_r      <= 3'd0;
            alu_op_r       <= 4'd0;
            alu_src_a_r    <= 1'b0;
            alu_src_b_r    <= 1'b0;
            wb_sel_r       <= 2'd0;
            pc_src_r       <= 2'd0;
        end else begin
            // Write strobes are single-cycle unless re-armed below
            reg_write_en_r <= 1'b0;
            pc_write_en_r  <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    // After reset the request rises one cycle late ("fetch pending")
                    if (imem_req_r && IMEM_READY) begin
                        ir_r       <= INSTRUCTION;
                        imem_req_r <= 1'b0;
                        state_r    <= ST_DECODE;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    cls_r       <= dec_cls_s;
                    imm_sel_r   <= dec_imm_sel_s;
                    alu_op_r    <= dec_alu_op_s;
                    alu_src_a_r <= dec_alu_src_a_s;
                    alu_src_b_r <= dec_alu_src_b_s;
                    wb_sel_r    <= dec_wb_sel_s;
                    case (dec_cls_s)
                        CLS_JAL:  pc_src_r <= PC_TARGET;
                        CLS_JALR: pc_src_r <= PC_JALR;
                        default:  pc_src_r <= PC_PLUS4;
                    endcase
                    if (dec_illegal_s || (dec_cls_s == CLS_SYSTEM)) begin
                        halt_r  <= 1'b1;
                        state_r <= ST_HALTED;
                    end else if (dec_cls_s == CLS_FENCE) begin
                        pc_write_en_r <= 1'b1;
                        state_r       <= ST_WRITEBACK;
                    end else begin
                        state_r <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (cls_r == CLS_BRANCH) begin
                        pc_src_r <= BRANCH_TAKEN ? PC_TARGET : PC_PLUS4;
                    end else begin
                        pc_src_r <= pc_src_r;
                    end
                    if ((cls_r == CLS_LOAD) || (cls_r == CLS_STORE)) begin
                        dmem_req_r <= 1'b1;
                        dmem_we_r  <= (cls_r == CLS_STORE);
                        state_r    <= ST_MEM;
                    end else begin
                        pc_write_en_r  <= 1'b1;
                        reg_write_en_r <= rd_write_s;
                        state_r        <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (DMEM_READY) begin
                        dmem_req_r     <= 1'b0;
                        dmem_we_r      <= 1'b0;
                        pc_write_en_r  <= 1'b1;
                        reg_write_en_r <= rd_write_s;
                        state_r        <= ST_WRITEBACK;
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_WRITEBACK: begin
                    // Next fetch request is issued straight out of writeback
                    imem_req_r <= 1'b1;
                    state_r    <= ST_FETCH;
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    imem_req_r <= 1'b0;
                    dmem_req_r <= 1'b0;
                    dmem_we_r  <= 1'b0;
                    halt_r     <= 1'b1;
                    state_r    <= ST_HALTED;
                end
            endcase
        end
    end

`ifdef INSTRET_COUNTER_EN
    logic [63:0] instret_r;

    // Retired-instruction counter; HALTED never reaches WRITEBACK so it freezes
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            instret_r <= 64'd0;
        end else if (state_r == ST_WRITEBACK) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign INSTRET = instret_r;
`endif

    assign IMEM_REQ      = imem_req_r;
    assign IR            = ir_r;
    assign IMM_SELECTION = imm_sel_r;
    assign ALU_OP        = alu_op_r;
    assign ALU_SRC_A     = alu_src_a_r;
    assign ALU_SRC_B     = alu_src_b_r;
    assign DMEM_REQ      = dmem_req_r;
    assign DMEM_WE       = dmem_we_r;
    assign REG_WRITE_EN  = reg_write_en_r;
    assign WB_SEL        = wb_sel_r;
    assign PC_WRITE_EN   = pc_write_en_r;
    assign PC_SRC        = pc_src_r;
    assign HALT          = halt_r;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Scoreboard bench: each driven instruction pushes its expected control
// outputs and latency; the monitor pops and compares on every PC_WRITE_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instruction;
    logic [31:0] ir;
    logic [2:0]  imm_selection;
    logic [3:0]  alu_op;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        reg_write_en;
    logic [1:0]  wb_sel;
    logic        pc_write_en;
    logic [1:0]  pc_src;
    logic        halt;
`ifdef INSTRET_COUNTER_EN
    logic [63:0] instret;
`endif

    always #5 clk = ~clk;

    control_sequencer dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .IMEM_REQ      (imem_req),
        .IMEM_READY    (imem_ready),
        .INSTRUCTION   (instruction),
        .IR            (ir),
        .IMM_SELECTION (imm_selection),
        .ALU_OP        (alu_op),
        .ALU_SRC_A     (alu_src_a),
        .ALU_SRC_B     (alu_src_b),
        .BRANCH_TAKEN  (branch_taken),
        .DMEM_REQ      (dmem_req),
        .DMEM_WE       (dmem_we),
        .DMEM_READY    (dmem_ready),
        .REG_WRITE_EN  (reg_write_en),
        .WB_SEL        (wb_sel),
        .PC_WRITE_EN   (pc_write_en),
        .PC_SRC        (pc_src),
`ifdef INSTRET_COUNTER_EN
        .INSTRET       (instret),
`endif
        .HALT          (halt)
    );

    typedef struct {
        logic [2:0] imm;
        logic       alu_a;
        logic       alu_b;
        logic [3:0] alu_op;
        logic [1:0] wb;
        logic [1:0] pcs;
        logic       reg_we;
        int         lat;
        int         mem_cyc;
        logic       mem_we;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   dmem_wait = 0;
    int   dmem_cnt  = 0;
    int   since     = 0;
    bit   req_seen  = 1'b0;
    int   mem_cyc   = 0;
    logic mem_we_seen = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] imm, input logic a, input logic b,
                                input logic [3:0] op, input logic [1:0] wb, input logic [1:0] pcs,
                                input logic we, input int lat, input int mc, input logic mwe);
        exp_t e;
        e.imm = imm; e.alu_a = a; e.alu_b = b; e.alu_op = op; e.wb = wb;
        e.pcs = pcs; e.reg_we = we; e.lat = lat; e.mem_cyc = mc; e.mem_we = mwe;
        return e;
    endfunction

    // Data-memory responder: asserts DMEM_READY in the (dmem_wait+1)-th request cycle
    initial begin
        dmem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dmem_req === 1'b1) begin
                dmem_cnt++;
                dmem_ready = (dmem_cnt > dmem_wait);
            end else begin
                dmem_cnt   = 0;
                dmem_ready = 1'b0;
            end
        end
    end

    // Monitor: latency from first IMEM_REQ cycle, memory cycles, scoreboard pop
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                req_seen = 1'b0;
                since    = 0;
                mem_cyc  = 0;
            end else begin
                if (imem_req === 1'b1 && !req_seen) begin
                    req_seen = 1'b1;
                    since    = 1;
                end else if (req_seen) begin
                    since++;
                end
                if (dmem_req === 1'b1) begin
                    mem_cyc++;
                    mem_we_seen = dmem_we;
                end
                if (reg_write_en === 1'b1 && pc_write_en !== 1'b1) check_eq("stray_reg_we", 64'd1, 64'd0);
                if (pc_write_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_wb", 64'd1, 64'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("imm_sel",   64'(imm_selection), 64'(mon_e.imm));
                        check_eq("alu_src_a", 64'(alu_src_a),     64'(mon_e.alu_a));
                        check_eq("alu_src_b", 64'(alu_src_b),     64'(mon_e.alu_b));
                        check_eq("alu_op",    64'(alu_op),        64'(mon_e.alu_op));
                        check_eq("wb_sel",    64'(wb_sel),        64'(mon_e.wb));
                        check_eq("pc_src",    64'(pc_src),        64'(mon_e.pcs));
                        check_eq("reg_we",    64'(reg_write_en),  64'(mon_e.reg_we));
                        check_eq("latency",   64'(since),         64'(mon_e.lat));
                        check_eq("mem_cycles", 64'(mem_cyc),      64'(mon_e.mem_cyc));
                        if (mon_e.mem_cyc > 0) check_eq("mem_we", 64'(mem_we_seen), 64'(mon_e.mem_we));
                    end
                    req_seen = 1'b0;
                    mem_cyc  = 0;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] instr, input int wait_cyc);
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_eq("imem_req_seen", 64'(imem_req), 64'd1);
        repeat (wait_cyc) begin
            @(posedge clk); #1;
        end
        instruction = instr;
        imem_ready  = 1'b1;
        @(posedge clk); #1;
        imem_ready  = 1'b0;
        instruction = $urandom;
        check_eq("ir_latch", 64'(ir), 64'(instr));
    endtask

    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                             input logic taken, input exp_t e);
        int n = 0;
        branch_taken = taken;
        dmem_wait    = dw;
        exp_q.push_back(e);
        fetch(instr, iw);
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check_eq("wb_done", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Called at posedge+1: assert reset mid-cycle, release, verify fetch restart
    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("reset_strobes", 64'({imem_req, dmem_req, dmem_we, reg_write_en, pc_write_en, halt}), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check_eq("req_before_edge", 64'(imem_req), 64'd0);
        @(posedge clk); #1;
        check_eq("fetch_restart", 64'(imem_req), 64'd1);
    endtask

    task automatic halt_test(input logic [31:0] instr);
        int cnt = 0;
        fetch(instr, 0);
        check_eq("halt_in_decode", 64'(halt), 64'd0);
        @(posedge clk); #1;
        check_eq("halt_set", 64'(halt), 64'd1);
        imem_ready = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if ((imem_req | dmem_req | pc_write_en | reg_write_en) === 1'b1) cnt++;
        end
        imem_ready = 1'b0;
        check_eq("halt_quiet", 64'(cnt), 64'd0);
        check_eq("halt_sticky", 64'(halt), 64'd1);
        check_eq("halt_ir_held", 64'(ir), 64'(instr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        imem_ready   = 1'b0;
        instruction  = 32'd0;
        branch_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", 64'({imem_req, dmem_req, dmem_we, reg_write_en, pc_write_en, halt,
                                        imm_selection, alu_op, alu_src_a, alu_src_b, wb_sel, pc_src}), 64'd0);
        check_eq("reset_ir", 64'(ir), 64'd0);
`ifdef INSTRET_COUNTER_EN
        check_eq("instret_reset", instret, 64'd0);
`endif
        #2 rst_n = 1'b1;
        #1;
        check_eq("req_before_first_edge", 64'(imem_req), 64'd0);
        @(posedge clk); #1;
        check_eq("first_req", 64'(imem_req), 64'd1);

        //          instr         iw dw tk   imm a  b  op       wb pcs we lat mc mwe
        run_instr(32'h00A00613, 0, 0, 1'b0, mk(3'd1, 1'b0, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b1, 4, 0, 1'b0)); // addi x12
        run_instr(32'h00001337, 0, 0, 1'b0, mk(3'd2, 1'b0, 1'b1, 4'b0000, 2'd3, 2'd0, 1'b1, 4, 0, 1'b0)); // lui x6
        run_instr(32'h00B323A3, 0, 2, 1'b0, mk(3'd3, 1'b0, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, 7, 3, 1'b1)); // sw
        run_instr(32'hFEC5CAE3, 0, 0, 1'b1, mk(3'd4, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd1, 1'b0, 4, 0, 1'b0)); // blt taken
        run_instr(32'hFEC5CAE3, 0, 0, 1'b0, mk(3'd4, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 4, 0, 1'b0)); // blt not taken
        run_instr(32'h4000006F, 0, 0, 1'b1, mk(3'd5, 1'b0, 1'b0, 4'b0000, 2'd2, 2'd1, 1'b0, 4, 0, 1'b0)); // jal x0
        run_instr(32'h40B50533, 0, 0, 1'b0, mk(3'd0, 1'b0, 1'b0, 4'b1000, 2'd0, 2'd0, 1'b1, 4, 0, 1'b0)); // sub
        run_instr(32'h4032D293, 0, 0, 1'b0, mk(3'd1, 1'b0, 1'b1, 4'b1101, 2'd0, 2'd0, 1'b1, 4, 0, 1'b0)); // srai
        run_instr(32'h40000093, 0, 0, 1'b0, mk(3'd1, 1'b0, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b1, 4, 0, 1'b0)); // addi imm bit30
        run_instr(32'h12345197, 0, 0, 1'b0, mk(3'd2, 1'b1, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b1, 4, 0, 1'b0)); // auipc
        run_instr(32'h000280E7, 0, 0, 1'b0, mk(3'd1, 1'b0, 1'b1, 4'b0000, 2'd2, 2'd2, 1'b1, 4, 0, 1'b0)); // jalr x1
        run_instr(32'h00432383, 2, 0, 1'b0, mk(3'd1, 1'b0, 1'b1, 4'b0000, 2'd1, 2'd0, 1'b1, 7, 1, 1'b0)); // lw, imem wait 2
        run_instr(32'h0000000F, 0, 0, 1'b0, mk(3'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 3, 0, 1'b0)); // fence
        run_instr(32'h00000013, 0, 0, 1'b0, mk(3'd1, 1'b0, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b0, 4, 0, 1'b0)); // nop (rd=x0)

        // Reset during a stalled load: request drops with reset, no write pulse
        dmem_wait = 1000;
        fetch(32'h00432383, 0);
        begin
            int n = 0;
            while (dmem_req !== 1'b1 && n < 10) begin
                @(posedge clk); #1; n++;
            end
        end
        check_eq("mem_req_up", 64'(dmem_req), 64'd1);
        @(posedge clk); #1;
        check_eq("mem_req_held", 64'(dmem_req), 64'd1);
        pulse_reset();
        dmem_wait = 0;
`ifdef INSTRET_COUNTER_EN
        check_eq("instret_after_reset", instret, 64'd0);
`endif
        run_instr(32'h00A00613, 0, 0, 1'b0, mk(3'd1, 1'b0, 1'b1, 4'b0000, 2'd0, 2'd0, 1'b1, 4, 0, 1'b0));
        run_instr(32'h4000006F, 0, 0, 1'b0, mk(3'd5, 1'b0, 1'b0, 4'b0000, 2'd2, 2'd1, 1'b0, 4, 0, 1'b0));
        run_instr(32'h0000000F, 0, 0, 1'b0, mk(3'd0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 1'b0, 3, 0, 1'b0));
`ifdef INSTRET_COUNTER_EN
        check_eq("instret_three", instret, 64'd3);
`endif

        halt_test(32'hFFFFFFFF);
`ifdef INSTRET_COUNTER_EN
        check_eq("instret_frozen", instret, 64'd3);
`endif
        @(posedge clk); #1;
        pulse_reset();
        halt_test(32'h00000073);   // ecall

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control FSM for the RV32I core. Fetches one instruction through a request/ready handshake, latches it, and decodes the opcode. It then sequences the shared datapath: immediate extractor, ALU, register file, data memory and PC through EXECUTE, MEM and WRITEBACK. It drives the immediate-type select, operand/writeback muxes and all write enables, so exactly one instruction is in flight at a time.

## Interface
- No parameters. Widths are fixed by RV32I.
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- IMEM_REQ  out  1  instruction fetch request, held until IMEM_READY
- IMEM_READY  in  1  INSTRUCTION valid this cycle
- INSTRUCTION  in  32  fetched instruction word
- IR  out  32  latched instruction, feeds immediate extractor and register-file addresses
- IMM_SELECTION  out  3  immediate type: 0 none, 1 I, 2 U, 3 S, 4 B, 5 UJ
- ALU_OP  out  4  {funct7[5], funct3} for OP; funct7[5] used only for SRAI in OP-IMM; 0000 (ADD) otherwise
- ALU_SRC_A  out  1  0 rs1, 1 PC (AUIPC)
- ALU_SRC_B  out  1  0 rs2, 1 immediate
- BRANCH_TAKEN  in  1  comparator result for IR's funct3, sampled in EXECUTE
- DMEM_REQ  out  1  data access request, held until DMEM_READY
- DMEM_WE  out  1  1 store, 0 load; valid while DMEM_REQ
- DMEM_READY  in  1  data access complete
- REG_WRITE_EN  out  1  one-cycle register-file write pulse
- WB_SEL  out  2  0 ALU, 1 load data, 2 PC+4, 3 immediate (LUI)
- PC_WRITE_EN  out  1  one-cycle PC update pulse
- PC_SRC  out  2  0 PC+4, 1 PC+imm (taken branch, JAL), 2 ALU result with bit0 cleared (JALR)
- HALT  out  1  sticky; ECALL, EBREAK or illegal opcode

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED.
- FETCH: IMEM_REQ=1. On IMEM_READY, IR<=INSTRUCTION and go to DECODE. Otherwise stay.
- DECODE: classify opcode, register IMM_SELECTION, ALU_*, WB_SEL and PC_SRC class.
  - SYSTEM or illegal opcode → HALTED.
  - FENCE → WRITEBACK as a NOP: PC+4, no register write.
  - Otherwise → EXECUTE.
- EXECUTE: ALU operates.
  - Branch: PC_SRC<=BRANCH_TAKEN ? 1 : 0.
  - LOAD/STORE → MEM. All else → WRITEBACK.
- MEM: DMEM_REQ=1, DMEM_WE=1 for STORE. Stay until DMEM_READY, then → WRITEBACK.
- WRITEBACK: PC_WRITE_EN=1. REG_WRITE_EN=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, and only when rd≠0. Then → FETCH.
- HALTED: HALT=1, all strobes 0, IR held. Exit only via reset.
- Control outputs are stable from DECODE exit until WRITEBACK exit.
- IMEM_READY outside FETCH and DMEM_READY outside MEM are ignored.

## Timing
- Reset (async assert): state=FETCH-pending. All outputs 0, IR=0, HALT=0.
- First IMEM_REQ appears in the first cycle after RESET_N deasserts.
- Zero-wait latency, FETCH to PC_WRITE_EN:
  - 4 cycles for ALU, branch, jump, LUI and AUIPC.
  - 5 cycles for load/store.
- Each wait cycle on IMEM_READY or DMEM_READY adds exactly one cycle.
- REQ signals are held continuously, never withdrawn before READY. READY in the request's first cycle completes it.
- Reset asserted mid-FETCH or mid-MEM drops REQ combinationally with reset. No write pulse is issued.

## Configuration
- INSTRET_COUNTER_EN defined: 64-bit output INSTRET increments on every WRITEBACK cycle, FENCE included. It resets to 0 and freezes in HALTED.
- Not defined: the INSTRET port and counter are absent. All other behaviour is identical.

## Structure
- Shared package/header, used by this block and the immediate extractor:
  - RV32I opcode constants.
  - IMM_SELECTION codes 0–5.
  - WB_SEL and PC_SRC encodings.
  - State encoding.
- One sub-module: opcode_decoder, purely combinational. Takes IR and produces the instruction class, IMM_SELECTION, ALU_OP, ALU_SRC_A/B, WB_SEL and illegal flag.
- The FSM, IR register, strobes and counter live in control_sequencer.

## Test plan
- 0x00A00613 (addi x12,x0,10), IMEM_READY immediate → IMM_SELECTION=1, ALU_SRC_B=1, WB_SEL=0; REG_WRITE_EN and PC_WRITE_EN pulse in cycle 4 with PC_SRC=0.
- 0x00001337 (lui x6,1) → IMM_SELECTION=2, WB_SEL=3, write in cycle 4. 0x00B323A3 (sw) with DMEM_READY delayed 2 cycles → IMM_SELECTION=3, DMEM_REQ/DMEM_WE held 3 cycles, no REG_WRITE_EN, PC_WRITE_EN in cycle 7.
- 0xFEC5CAE3 (blt) with BRANCH_TAKEN=1 → IMM_SELECTION=4, PC_SRC=1. Repeat with BRANCH_TAKEN=0 → PC_SRC=0. No register write in either case.
- 0x4000006F (jal x0,1024) → IMM_SELECTION=5, PC_SRC=1, WB_SEL=2, REG_WRITE_EN=0 (rd=x0). 0xFFFFFFFF → HALT=1 after DECODE, no further IMEM_REQ for 20 cycles.
- RESET_N pulsed low during MEM wait of a load → DMEM_REQ drops the same instant, no write pulse. Fetch restarts one cycle after release. With INSTRET_COUNTER_EN, INSTRET=0 after reset and 3 after three completed instructions.
